// File: rtl/fetch_buffer.sv
// fetch_buffer: pairs IM read-data beats with snooped AR PCs and queues them for decode.
// Optional FETCH_BUF_BYPASS_EN: zero-latency R-to-decode path when the queue is idle.
module fetch_buffer #(
  parameter int XLEN            = 32,
  parameter int DEPTH           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_im_arvalid,
  input  logic            i_im_arready,
  input  logic [XLEN-1:0] i_im_araddr,
  output logic            o_im_rready,
  input  logic            i_im_rvalid,
  input  logic [XLEN-1:0] i_im_rdata,
  input  logic [1:0]      i_im_rresp,
  input  logic            i_flush,
  output logic            o_fetch_credit,
  output logic            o_id_valid,
  input  logic            i_id_ready,
  output logic [XLEN-1:0] o_id_instr,
  output logic [XLEN-1:0] o_id_pc,
  output logic            o_id_fault
);

  localparam int QW = $clog2(DEPTH);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            fault;
  } ent_t;

  ent_t            q_mem [DEPTH];
  logic [XLEN-1:0] pc_mem [MAX_OUTSTANDING];

  logic [QW-1:0] q_head, q_tail;
  logic [QW:0]   q_cnt;
  logic [PW-1:0] pc_head, pc_tail;
  logic [CW-1:0] outst, drop_cnt, outst_nxt;
  logic [CW:0]   inflight;
  logic          rdy;

  logic ar_ev, r_ev, keep, bypass, push, pop;
  ent_t beat, head;

  assign ar_ev = i_im_arvalid & i_im_arready;
  assign r_ev  = i_im_rvalid & rdy;
  assign beat  = {i_im_rdata, pc_mem[pc_head], |i_im_rresp};
  assign head  = q_mem[q_head];

  // Beats already in flight when a flush hits are consumed but never queued.
  assign keep = r_ev & (drop_cnt == '0) & ~i_flush;

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = keep & (q_cnt == '0);
`else
  assign bypass = 1'b0;
`endif

  assign push = keep & ~(bypass & i_id_ready);
  assign pop  = (q_cnt != '0) & i_id_ready & ~i_flush;

  assign outst_nxt = outst + CW'(ar_ev) - CW'(r_ev);
  assign inflight  = (CW+1)'(q_cnt) + (CW+1)'(outst);

  assign o_im_rready    = rdy;
  assign o_fetch_credit = rdy & (inflight < (CW+1)'(DEPTH));
  assign o_id_valid     = (q_cnt != '0) | bypass;

  always_comb begin
    o_id_instr = '0;
    o_id_pc    = '0;
    o_id_fault = 1'b0;
    if (q_cnt != '0) begin
      o_id_instr = head.instr;
      o_id_pc    = head.pc;
      o_id_fault = head.fault;
    end else if (bypass) begin
      o_id_instr = beat.instr;
      o_id_pc    = beat.pc;
      o_id_fault = beat.fault;
    end
  end

  always_ff @(posedge clk) begin
    if (ar_ev) pc_mem[pc_tail] <= i_im_araddr;
    if (push)  q_mem[q_tail]   <= beat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdy      <= 1'b0;
      outst    <= '0;
      drop_cnt <= '0;
      pc_head  <= '0;
      pc_tail  <= '0;
      q_head   <= '0;
      q_tail   <= '0;
      q_cnt    <= '0;
    end else begin
      rdy   <= 1'b1;
      outst <= outst_nxt;
      if (ar_ev) pc_tail <= pc_tail + 1'b1;
      if (r_ev)  pc_head <= pc_head + 1'b1;
      // Recomputed from scratch so back-to-back flushes never double count.
      if (i_flush)
        drop_cnt <= outst_nxt - CW'(ar_ev);
      else if (r_ev && drop_cnt != '0)
        drop_cnt <= drop_cnt - 1'b1;
      if (i_flush) begin
        q_head <= '0;
        q_tail <= '0;
        q_cnt  <= '0;
      end else begin
        if (push) q_tail <= q_tail + 1'b1;
        if (pop)  q_head <= q_head + 1'b1;
        q_cnt <= q_cnt + (QW+1)'(push) - (QW+1)'(pop);
      end
    end
  end

  a_credit: assert property (@(posedge clk) disable iff (rst)
    ar_ev |-> o_fetch_credit);

endmodule
